// File: rtl/uart_frame_decoder.sv
// Purpose: decodes UART byte frames AA,CMD,LEN,payload[LEN],CHK into a command/payload record.
// Latency: frame_valid/frame_error pulse one cycle after the deciding data_ready strobe (or timeout cycle).
// Backpressure: none; every data_ready strobe is consumed in the cycle it arrives.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   data_ready   one-cycle strobe qualifying data_in
//   data_in      received byte
//   frame_valid  one-cycle pulse on an accepted frame
//   frame_error  one-cycle pulse on an aborted frame
//   err_type     abort cause (01 checksum, 10 length, 11 timeout), held between pulses
//   cmd_out      command byte of the last good frame
//   len_out      payload length of the last good frame
//   payload_out  payload of the last good frame, byte0 in [7:0], unused bytes zero
module uart_frame_decoder #(
    parameter int CLOCK_RATE    = 100_000_000,
    parameter int BAUDE_RATE    = 9600,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_ready,
    input  logic [7:0]  data_in,
    output logic        frame_valid,
    output logic        frame_error,
    output logic [1:0]  err_type,
    output logic [7:0]  cmd_out,
    output logic [2:0]  len_out,
    output logic [31:0] payload_out
);

    // One byte-time on the wire is 10 bit-times (start + 8 data + stop).
    localparam int              LIMIT    = TIMEOUT_BYTES * 10 * (CLOCK_RATE / BAUDE_RATE);
    localparam int              TW       = $clog2(LIMIT) + 1;
    localparam logic [TW-1:0]   LIMIT_M1 = TW'(LIMIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_LEN,
        GET_PAYLOAD,
        GET_CHK
    } state_t;

    state_t         r_state;
    logic [TW-1:0]  r_timer;
    logic [7:0]     r_sum;
    logic [1:0]     r_idx;
    logic [7:0]     r_cmd;
    logic [2:0]     r_len;
    logic [31:0]    r_pay;

    logic           w_expire;
    logic           w_last;

    // The timer holds the number of idle cycles already seen since the last
    // strobe; the cycle in which it would reach LIMIT is the limit cycle.
    // A strobe in that same cycle wins, so the expiry is masked by data_ready.
    assign w_expire = (r_state != IDLE) && !data_ready && (r_timer == LIMIT_M1);

    // Current payload byte is the LEN-th one.
    assign w_last   = (({1'b0, r_idx} + 3'd1) == r_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_cmd       <= '0;
            r_len       <= '0;
            r_pay       <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            err_type    <= 2'b00;
            cmd_out     <= '0;
            len_out     <= '0;
            payload_out <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;

            if (r_state == IDLE || data_ready || w_expire) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end

            if (w_expire) begin
                frame_error <= 1'b1;
                err_type    <= 2'b11;
                r_state     <= IDLE;
            end else if (data_ready) begin
                unique case (r_state)
                    IDLE: begin
                        if (data_in == 8'hAA) begin
                            // Clearing the payload here gives zero-fill above LEN for free.
                            r_pay   <= '0;
                            r_sum   <= '0;
                            r_idx   <= '0;
                            r_state <= GET_CMD;
                        end
                    end
                    GET_CMD: begin
                        r_cmd   <= data_in;
                        r_sum   <= data_in;
                        r_state <= GET_LEN;
                    end
                    GET_LEN: begin
                        if (data_in > 8'd4) begin
                            frame_error <= 1'b1;
                            err_type    <= 2'b10;
                            r_state     <= IDLE;
                        end else begin
                            r_len   <= data_in[2:0];
                            r_sum   <= r_sum + data_in;
                            r_idx   <= '0;
                            r_state <= (data_in == 8'd0) ? GET_CHK : GET_PAYLOAD;
                        end
                    end
                    GET_PAYLOAD: begin
                        // A mid-frame 0xAA is plain payload; no resynchronisation.
                        r_pay[{r_idx, 3'b000} +: 8] <= data_in;
                        r_sum <= r_sum + data_in;
                        r_idx <= r_idx + 2'd1;
                        if (w_last) begin
                            r_state <= GET_CHK;
                        end
                    end
                    GET_CHK: begin
                        if (data_in == r_sum) begin
                            frame_valid <= 1'b1;
                            cmd_out     <= r_cmd;
                            len_out     <= r_len;
                            payload_out <= r_pay;
                        end else begin
                            frame_error <= 1'b1;
                            err_type    <= 2'b01;
                        end
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Purpose: directed self-checking bench for uart_frame_decoder.
// Latency: checks pulses #1 after the edge that captures the deciding byte.
// Backpressure: not applicable; bytes are driven as one-cycle strobes.
module tb_uart_frame_decoder;

    // 10 clocks per bit -> 100 clocks per byte -> 400-cycle timeout.
    localparam int CLOCK_RATE    = 1000;
    localparam int BAUDE_RATE    = 100;
    localparam int TIMEOUT_BYTES = 4;
    localparam int LIMIT         = TIMEOUT_BYTES * 10 * (CLOCK_RATE / BAUDE_RATE);

    logic        clk;
    logic        reset;
    logic        data_ready;
    logic [7:0]  data_in;
    logic        frame_valid;
    logic        frame_error;
    logic [1:0]  err_type;
    logic [7:0]  cmd_out;
    logic [2:0]  len_out;
    logic [31:0] payload_out;

    int n_checks;
    int n_errors;
    int cnt_valid;
    int cnt_error;
    int cnt_both;
    int exp_valid;
    int exp_error;

    uart_frame_decoder #(
        .CLOCK_RATE   (CLOCK_RATE),
        .BAUDE_RATE   (BAUDE_RATE),
        .TIMEOUT_BYTES(TIMEOUT_BYTES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_ready (data_ready),
        .data_in    (data_in),
        .frame_valid(frame_valid),
        .frame_error(frame_error),
        .err_type   (err_type),
        .cmd_out    (cmd_out),
        .len_out    (len_out),
        .payload_out(payload_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: each one-cycle pulse spans exactly one falling edge.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) cnt_valid++;
        if (frame_error === 1'b1) cnt_error++;
        if (frame_valid === 1'b1 && frame_error === 1'b1) cnt_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One-cycle strobe starting now (caller sits #1 after an edge); returns #1 after the capturing edge.
    task automatic strobe(input logic [7:0] b);
        data_in    = b;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
    endtask

    // One idle cycle, then a strobe.
    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        strobe(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_nvalid"}, cnt_valid, exp_valid);
        check({tag, "_nerror"}, cnt_error, exp_error);
    endtask

    task automatic check_good(input string tag, input logic [7:0] c, input logic [2:0] l,
                              input logic [31:0] p);
        check({tag, "_valid"}, frame_valid, 1'b1);
        check({tag, "_error"}, frame_error, 1'b0);
        check({tag, "_cmd"},   cmd_out,     c);
        check({tag, "_len"},   len_out,     l);
        check({tag, "_pay"},   payload_out, p);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cnt_valid  = 0;
        cnt_error  = 0;
        cnt_both   = 0;
        exp_valid  = 0;
        exp_error  = 0;
        reset      = 1'b1;
        data_ready = 1'b0;
        data_in    = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", frame_valid, 1'b0);
        check("rst_error", frame_error, 1'b0);
        check("rst_etype", err_type,    2'b00);
        check("rst_cmd",   cmd_out,     8'h00);
        check("rst_len",   len_out,     3'd0);
        check("rst_pay",   payload_out, 32'h0);
        reset = 1'b0;
        idle(2);

        // Good frame: 10+02+34+12 = 58
        send(8'hAA); send(8'h10); send(8'h02); send(8'h34); send(8'h12); send(8'h58);
        exp_valid++;
        check_good("good", 8'h10, 3'd2, 32'h0000_1234);
        idle(1);
        check("good_pulse_end", frame_valid, 1'b0);
        check_counts("good");

        // Bad checksum: 10+01+FF = 0x110 -> 10, CHK 00 mismatches; outputs keep previous frame
        send(8'hAA); send(8'h10); send(8'h01); send(8'hFF); send(8'h00);
        exp_error++;
        check("badchk_error", frame_error, 1'b1);
        check("badchk_valid", frame_valid, 1'b0);
        check("badchk_etype", err_type,    2'b01);
        check("badchk_cmd",   cmd_out,     8'h10);
        check("badchk_len",   len_out,     3'd2);
        check("badchk_pay",   payload_out, 32'h0000_1234);
        idle(1);
        check_counts("badchk");

        // Zero-length frame clears the previous payload
        send(8'hAA); send(8'h05); send(8'h00); send(8'h05);
        exp_valid++;
        check_good("zlen", 8'h05, 3'd0, 32'h0);

        // Checksum with carry: 80+03+90+01+02 = 0x116 -> 16; top byte zero-filled
        send(8'hAA); send(8'h80); send(8'h03); send(8'h90); send(8'h01); send(8'h02); send(8'h16);
        exp_valid++;
        check_good("carry", 8'h80, 3'd3, 32'h0002_0190);

        // Mid-frame AA is payload: 22+04+AA+01+02+03 = D6
        send(8'hAA); send(8'h22); send(8'h04); send(8'hAA); send(8'h01); send(8'h02);
        send(8'h03); send(8'hD6);
        exp_valid++;
        check_good("midaa", 8'h22, 3'd4, 32'h0302_01AA);

        // Bad length, err_type held afterwards, next AA starts a fresh frame
        send(8'hAA); send(8'h10); send(8'h07);
        exp_error++;
        check("badlen_error", frame_error, 1'b1);
        check("badlen_etype", err_type,    2'b10);
        idle(3);
        check("badlen_hold_error", frame_error, 1'b0);
        check("badlen_hold_etype", err_type,    2'b10);
        send(8'hAA); send(8'h01); send(8'h01); send(8'h7F); send(8'h81);
        exp_valid++;
        check_good("afterlen", 8'h01, 3'd1, 32'h0000_007F);
        idle(1);
        check_counts("badlen");

        // Timeout: error appears after exactly LIMIT idle cycles, not one earlier
        send(8'hAA); send(8'h10);
        idle(LIMIT - 1);
        check("tmo_early", frame_error, 1'b0);
        idle(1);
        exp_error++;
        check("tmo_error", frame_error, 1'b1);
        check("tmo_etype", err_type,    2'b11);
        idle(1);
        check_counts("tmo");

        // Timeout tie: strobe on the limit cycle is taken and no error fires
        send(8'hAA); send(8'h10);
        idle(LIMIT - 1);
        strobe(8'h02);
        check("tie_error", frame_error, 1'b0);
        send(8'h34); send(8'h12); send(8'h58);
        exp_valid++;
        check_good("tie", 8'h10, 3'd2, 32'h0000_1234);
        check("tie_etype_held", err_type, 2'b11);
        idle(1);
        check_counts("tie");

        // Reset mid-frame discards the partial frame silently
        send(8'hAA); send(8'h10); send(8'h02);
        reset = 1'b1;
        #1;
        check("mrst_cmd",   cmd_out,     8'h00);
        check("mrst_len",   len_out,     3'd0);
        check("mrst_pay",   payload_out, 32'h0);
        check("mrst_etype", err_type,    2'b00);
        idle(2);
        reset = 1'b0;
        send(8'h34); send(8'h12); send(8'h58);
        idle(2);
        check_counts("mrst");
        send(8'hAA); send(8'h10); send(8'h02); send(8'h34); send(8'h12); send(8'h58);
        exp_valid++;
        check_good("mrst_good", 8'h10, 3'd2, 32'h0000_1234);
        idle(2);
        check_counts("final");
        check("exclusive", cnt_both, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUDE_RATE, default 9600, serial bit rate in baud.
REQ-003 SHALL have parameter TIMEOUT_BYTES, default 4, the number of idle byte-times that aborts a partial frame.
REQ-004 SHALL have port clk  input  1  the single system clock; all logic is on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_ready  input  1  one-cycle strobe marking a valid received byte.
REQ-007 SHALL have port data_in  input  8  received byte, sampled only when data_ready=1.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse when a good frame is accepted.
REQ-009 SHALL have port frame_error  output  1  one-cycle pulse when a frame is aborted.
REQ-010 SHALL have port err_type  output  2  abort cause, encoded 01=checksum, 10=length, 11=timeout.
REQ-011 SHALL have port cmd_out  output  8  command byte of the last good frame.
REQ-012 SHALL have port len_out  output  3  payload length of the last good frame.
REQ-013 SHALL have port payload_out  output  32  payload of the last good frame; byte0 is in [7:0].

Function
REQ-014 SHALL use the frame format 0xAA, CMD, LEN, LEN payload bytes, CHK, with LEN in 0..4.
REQ-015 SHALL run the FSM states IDLE, GET_CMD, GET_LEN, GET_PAYLOAD, GET_CHK, and SHALL change state only on a data_ready cycle or a timeout.
REQ-016 SHALL, in IDLE, go to GET_CMD on byte 0xAA and ignore every other byte.
REQ-017 SHALL, in GET_CMD, store CMD and go to GET_LEN.
REQ-018 SHALL, in GET_LEN, handle LEN>4 as a length error: pulse frame_error with err_type=10, then go to IDLE.
REQ-019 SHALL, in GET_LEN, go to GET_CHK when LEN=0 and to GET_PAYLOAD otherwise.
REQ-020 SHALL, in GET_PAYLOAD, store byte i into payload bits [8i+7:8i] and go to GET_CHK after the LEN-th byte.
REQ-021 SHALL compute the checksum as the 8-bit modulo-256 sum of CMD, LEN and all payload bytes, with carries discarded.
REQ-022 SHALL, in GET_CHK, compare CHK with the running sum; on a match, pulse frame_valid one cycle after the CHK strobe and update cmd_out, len_out and payload_out in that same cycle.
REQ-023 SHALL zero-fill payload_out bytes at index LEN and above on a good frame.
REQ-024 SHALL, in GET_CHK on a mismatch, pulse frame_error with err_type=01 one cycle after the strobe and leave cmd_out, len_out and payload_out unchanged.
REQ-025 SHALL return to IDLE after GET_CHK in every case.
REQ-026 SHALL keep an idle timer, width $clog2 of the limit plus 1, that counts only outside IDLE and clears on every data_ready.
REQ-027 SHALL set the timer limit to TIMEOUT_BYTES*10*(CLOCK_RATE/BAUDE_RATE) cycles.
REQ-028 SHALL, when the timer reaches its limit, pulse frame_error with err_type=11 and go to IDLE.
REQ-029 SHALL give data_ready priority over a timeout that expires in the same cycle, so the byte is processed and the timer clears.
REQ-030 SHALL treat a 0xAA received mid-frame as ordinary data, with no resynchronisation.
REQ-031 SHALL hold err_type at its last value between error pulses.
REQ-032 SHALL never assert frame_valid and frame_error in the same cycle.
REQ-033 SHALL register all outputs.

Reset
REQ-034 SHALL, on reset, go to IDLE and clear the timer, running sum and byte index.
REQ-035 SHALL, on reset, drive frame_valid=0, frame_error=0, err_type=00, cmd_out=0, len_out=0 and payload_out=0.
REQ-036 SHALL, on reset asserted mid-frame, discard the partial frame without any pulse and accept a new frame after reset deasserts.

Verification
REQ-037 SHALL cover a good frame: bytes AA 10 02 34 12 58 -> one frame_valid pulse, cmd_out=10, len_out=2, payload_out=00001234.
REQ-038 SHALL cover a zero-length frame: AA 05 00 05 -> frame_valid, cmd_out=05, len_out=0, payload_out=0.
REQ-039 SHALL cover a bad checksum: AA 10 01 FF 00 -> frame_error with err_type=01, and outputs still holding the previous frame.
REQ-040 SHALL cover a bad length: AA 10 07 -> frame_error with err_type=10, after which the next AA starts a new frame.
REQ-041 SHALL cover a timeout: AA 10, then no strobe for the full limit -> frame_error with err_type=11 exactly at the limit cycle.
REQ-042 SHALL cover the timeout tie: a data_ready on the limit cycle -> no error, and the byte is accepted.
REQ-043 SHALL cover reset mid-frame: reset after AA 10 02 -> all outputs zero and no pulses, after which a full good frame is decoded.
